// File: rtl/sincpde_pkg.sv
// Shared types and constants for the sinc pulse framer and its history buffer.
package sincpde_pkg;

    localparam int SAMPLE_W = 18;
    localparam int NSAMP    = 11;

    typedef logic [SAMPLE_W-1:0]            sample_t;
    typedef logic [NSAMP-1:0][SAMPLE_W-1:0] window_t;

    typedef enum logic [1:0] {FILL, ARMED, POST, GAP} state_t;

endpackage

// File: rtl/sincpde_framer_hist.sv
// Sample history shifted on i_valid; element NSAMP-1 is the newest, element 0 the oldest.
// Snapshot is the register contents, so it reflects every sample accepted up to the last edge.
module sincpde_framer_hist
    import sincpde_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    input  logic [SAMPLE_W-1:0]            i_data,
    output logic [NSAMP-1:0][SAMPLE_W-1:0] o_snap
);

    logic [NSAMP-1:0][SAMPLE_W-1:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
        end else if (i_valid) begin
            r_hist <= {i_data, r_hist[NSAMP-1:1]};
        end
    end

    assign o_snap = r_hist;

endmodule

// File: rtl/sincpde_framer.sv
// Rising-crossing pulse framer: captures a window around the trigger and strobes sync_out one cycle
// after the final post-trigger sample (one more with SINCPDE_FRAMER_BASELINE_EN); triggers while busy are counted, never queued.
module sincpde_framer
    import sincpde_pkg::*;
#(
    parameter int PRE        = 4,
    parameter int GAP_CYCLES = 16,
    parameter int DROP_W     = 16
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic [SAMPLE_W-1:0] threshold,
    output logic                sync_out,
    output logic [SAMPLE_W-1:0] sample0,
    output logic [SAMPLE_W-1:0] sample1,
    output logic [SAMPLE_W-1:0] sample2,
    output logic [SAMPLE_W-1:0] sample3,
    output logic [SAMPLE_W-1:0] sample4,
    output logic [SAMPLE_W-1:0] sample5,
    output logic [SAMPLE_W-1:0] sample6,
    output logic [SAMPLE_W-1:0] sample7,
    output logic [SAMPLE_W-1:0] sample8,
    output logic [SAMPLE_W-1:0] sample9,
    output logic [SAMPLE_W-1:0] sample10,
    output logic                busy,
    output logic [DROP_W-1:0]   drop_cnt
);

    localparam int POST_LEN = NSAMP - 1 - PRE;
    localparam int CNT_W    = $clog2(GAP_CYCLES + NSAMP + 1);

    logic [NSAMP-1:0][SAMPLE_W-1:0] w_snap;
    logic [NSAMP-1:0][SAMPLE_W-1:0] r_samp;
    logic [SAMPLE_W-1:0]            r_prev;
    logic [CNT_W-1:0]               r_cnt;
    logic [DROP_W-1:0]              r_drop;
    state_t                         r_state;
    logic                           r_busy;
    logic                           r_sync;
    logic                           w_trig;
    logic                           w_cap;

    sincpde_framer_hist u_hist (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .i_data  (in_data),
        .o_snap  (w_snap)
    );

    assign w_trig = in_valid && (in_data >= threshold) && (r_prev < threshold);
    assign w_cap  = (r_state == POST) && (r_cnt == '0);

    // r_cnt is shared: fill count up in FILL, post samples down in POST, holdoff down in GAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_prev  <= '0;
            r_busy  <= 1'b0;
            r_drop  <= '0;
        end else begin
            if (in_valid) begin
                r_prev <= in_data;
            end
            case (r_state)
                FILL: begin
                    if (in_valid) begin
                        if (r_cnt == CNT_W'(PRE - 1)) begin
                            r_state <= ARMED;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (w_trig) begin
                        r_state <= POST;
                        r_cnt   <= CNT_W'(POST_LEN);
                        r_busy  <= 1'b1;
                    end
                end
                POST: begin
                    if (r_cnt == '0) begin
                        r_state <= GAP;
                        r_cnt   <= CNT_W'(GAP_CYCLES);
                    end else if (in_valid) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= ARMED;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= FILL;
            endcase
            if (w_trig && (r_state == POST || r_state == GAP) && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

`ifdef SINCPDE_FRAMER_BASELINE_EN
    logic [NSAMP-1:0][SAMPLE_W-1:0] r_raw;
    logic                           r_pend;

    // Raw window is latched first; the subtraction stage then lands with sync_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_raw  <= '0;
            r_pend <= 1'b0;
            r_samp <= '0;
            r_sync <= 1'b0;
        end else begin
            r_pend <= w_cap;
            r_sync <= r_pend;
            if (w_cap) begin
                r_raw <= w_snap;
            end
            if (r_pend) begin
                for (int i = 0; i < NSAMP; i++) begin
                    r_samp[i] <= (r_raw[i] > r_raw[0]) ? (r_raw[i] - r_raw[0]) : '0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_samp <= '0;
            r_sync <= 1'b0;
        end else begin
            r_sync <= w_cap;
            if (w_cap) begin
                r_samp <= w_snap;
            end
        end
    end
`endif

    assign sync_out = r_sync;
    assign busy     = r_busy;
    assign drop_cnt = r_drop;
    assign sample0  = r_samp[0];
    assign sample1  = r_samp[1];
    assign sample2  = r_samp[2];
    assign sample3  = r_samp[3];
    assign sample4  = r_samp[4];
    assign sample5  = r_samp[5];
    assign sample6  = r_samp[6];
    assign sample7  = r_samp[7];
    assign sample8  = r_samp[8];
    assign sample9  = r_samp[9];
    assign sample10 = r_samp[10];

endmodule

// File: tb/tb_sincpde_framer.sv
// Bench for sincpde_framer: directed scenarios plus a randomized stream against an event-level model.
module tb_sincpde_framer;
    import sincpde_pkg::*;

    localparam int PRE      = 4;
    localparam int POST_LEN = NSAMP - 1 - PRE;
    localparam int GAP_CYC  = 16;
    localparam int DROP_W   = 16;
`ifdef SINCPDE_FRAMER_BASELINE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic [SAMPLE_W-1:0] in_data = '0;
    logic [SAMPLE_W-1:0] threshold = '0;
    logic                sync_out, busy;
    logic [SAMPLE_W-1:0] sample0, sample1, sample2, sample3, sample4, sample5;
    logic [SAMPLE_W-1:0] sample6, sample7, sample8, sample9, sample10;
    logic [DROP_W-1:0]   drop_cnt;
    window_t             dut_win;

    sincpde_framer #(.PRE(PRE), .GAP_CYCLES(GAP_CYC), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .threshold(threshold),
        .sync_out(sync_out),
        .sample0(sample0), .sample1(sample1), .sample2(sample2), .sample3(sample3),
        .sample4(sample4), .sample5(sample5), .sample6(sample6), .sample7(sample7),
        .sample8(sample8), .sample9(sample9), .sample10(sample10),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    assign dut_win = {sample10, sample9, sample8, sample7, sample6, sample5,
                      sample4, sample3, sample2, sample1, sample0};

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_sync = 0;

    // Reference model: the accepted sample list plus the edge numbers of pending events.
    sample_t           seen[$];
    int                edge_no = 0;
    bit                in_post = 1'b0;
    int                trig_idx = 0;
    int                cap_edge = -1;
    int                sync_edge = -1;
    bit                m_busy = 1'b0;
    bit                exp_sync = 1'b0;
    logic [DROP_W-1:0] m_drop = '0;
    window_t           m_win = '0;
    window_t           pend_win = '0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    function automatic window_t make_window(input int tidx);
        window_t w;
        sample_t base;
        sample_t raw;
        base = seen[tidx - PRE];
        for (int i = 0; i < NSAMP; i++) begin
            raw = seen[tidx - PRE + i];
`ifdef SINCPDE_FRAMER_BASELINE_EN
            w[i] = (raw > base) ? raw - base : '0;
`else
            w[i] = raw;
`endif
        end
        return w;
    endfunction

    function automatic window_t pack_win(input int v[NSAMP]);
        window_t w;
        for (int i = 0; i < NSAMP; i++) w[i] = SAMPLE_W'(v[i]);
        return w;
    endfunction

    task automatic model_reset();
        edge_no++;
        seen.delete();
        in_post   = 1'b0;
        cap_edge  = -1;
        sync_edge = -1;
        m_busy    = 1'b0;
        exp_sync  = 1'b0;
        m_drop    = '0;
        m_win     = '0;
    endtask

    task automatic model_edge(input logic v, input sample_t d);
        bit      busy_before;
        sample_t prev;
        busy_before = m_busy;
        edge_no++;
        exp_sync = (edge_no == sync_edge);
        if (exp_sync) m_win = pend_win;
        if (v) begin
            prev = (seen.size() == 0) ? '0 : seen[$];
            seen.push_back(d);
            if (d >= threshold && prev < threshold && seen.size() > PRE) begin
                if (busy_before) begin
                    if (m_drop != '1) m_drop = m_drop + 1'b1;
                end else begin
                    in_post  = 1'b1;
                    trig_idx = seen.size() - 1;
                    cap_edge = -1;
                end
            end
        end
        if (in_post && cap_edge < 0 && seen.size() == trig_idx + 1 + POST_LEN) begin
            cap_edge  = edge_no + 1;
            sync_edge = cap_edge + EXTRA;
            pend_win  = make_window(trig_idx);
        end
        m_busy = in_post && (cap_edge < 0 || edge_no <= cap_edge + GAP_CYC - 1);
        if (!m_busy) in_post = 1'b0;
    endtask

    task automatic step(input logic r, input logic v, input sample_t d);
        rst = r;
        in_valid = v;
        in_data = d;
        @(posedge clk);
        if (r) model_reset();
        else   model_edge(v, d);
        #1;
        chk("sync_out", 256'(sync_out), 256'(exp_sync));
        chk("busy", 256'(busy), 256'(m_busy));
        chk("drop_cnt", 256'(drop_cnt), 256'(m_drop));
        chk("window", 256'(dut_win), 256'(m_win));
        if (sync_out) n_sync++;
    endtask

    int      basic[12] = '{23, 23, 23, 22, 169, 1697, 2833, 1640, 465, 81, 5, 1};
    int      fill_seq[16] = '{0, 2000, 0, 0, 0, 0, 0, 0, 0, 2000, 700, 700, 700, 700, 700, 700};
`ifdef SINCPDE_FRAMER_BASELINE_EN
    int      basic_exp[NSAMP] = '{0, 0, 0, 146, 1674, 2810, 1617, 442, 58, 0, 0};
`else
    int      basic_exp[NSAMP] = '{23, 23, 22, 169, 1697, 2833, 1640, 465, 81, 5, 1};
`endif
    int      fill_exp[NSAMP] = '{0, 0, 0, 0, 2000, 700, 700, 700, 700, 700, 700};
    int      s0;

    initial begin
        threshold = 18'd1000;
        step(1, 0, '0);
        step(1, 1, 18'd5000);
        chk("reset_win", 256'(dut_win), 256'(0));
        chk("reset_busy", 256'(busy), 256'(0));

        // Basic capture, then a drop inside the holdoff and a capture after it.
        s0 = n_sync;
        for (int i = 0; i < 12; i++) step(0, 1, SAMPLE_W'(basic[i]));
        chk("basic_no_early_sync", 256'(sync_out), 256'(0));
        repeat (1 + EXTRA) step(0, 0, '0);
        chk("basic_sync", 256'(sync_out), 256'(1));
        chk("basic_win", 256'(dut_win), 256'(pack_win(basic_exp)));
        chk("basic_drop", 256'(drop_cnt), 256'(0));
        step(0, 1, 18'd10);
        step(0, 1, 18'd10);
        step(0, 1, 18'd3000);
        chk("gap_drop", 256'(drop_cnt), 256'(1));
        repeat (20) step(0, 0, '0);
        chk("gap_no_second_sync", 256'(n_sync - s0), 256'(1));
        chk("gap_win_held", 256'(dut_win), 256'(pack_win(basic_exp)));
        step(0, 1, 18'd10);
        step(0, 1, 18'd3000);
        repeat (6) step(0, 1, 18'd500);
        repeat (2 + EXTRA) step(0, 0, '0);
        chk("after_gap_capture", 256'(n_sync - s0), 256'(2));
        chk("after_gap_drop", 256'(drop_cnt), 256'(1));

        // Stalled stream: valid on every other cycle.
        step(1, 0, '0);
        s0 = n_sync;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, SAMPLE_W'(basic[i]));
            step(0, 0, SAMPLE_W'($urandom_range(0, 5000)));
        end
        repeat (3) step(0, 0, '0);
        chk("stall_sync_cnt", 256'(n_sync - s0), 256'(1));
        chk("stall_win", 256'(dut_win), 256'(pack_win(basic_exp)));

        // Crossing during FILL is ignored; the later one is captured.
        step(1, 0, '0);
        s0 = n_sync;
        for (int i = 0; i < 16; i++) step(0, 1, SAMPLE_W'(fill_seq[i]));
        repeat (3) step(0, 0, '0);
        chk("fill_drop", 256'(drop_cnt), 256'(0));
        chk("fill_sync_cnt", 256'(n_sync - s0), 256'(1));
        chk("fill_win", 256'(dut_win), 256'(pack_win(fill_exp)));

        // Reset two samples after a trigger.
        step(1, 0, '0);
        s0 = n_sync;
        repeat (5) step(0, 1, 18'd0);
        step(0, 1, 18'd2000);
        step(0, 1, 18'd700);
        step(0, 1, 18'd700);
        step(1, 1, 18'd700);
        chk("rst_post_sync", 256'(sync_out), 256'(0));
        chk("rst_post_busy", 256'(busy), 256'(0));
        chk("rst_post_win", 256'(dut_win), 256'(0));
        repeat (4) step(0, 1, 18'd100);
        step(0, 1, 18'd2000);
        repeat (6) step(0, 1, 18'd700);
        repeat (3) step(0, 0, '0);
        chk("rst_post_recapture", 256'(n_sync - s0), 256'(1));

        // Randomized stream with occasional resets and threshold changes (including zero).
        threshold = 18'd1500;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                step(1, 0, '0);
            end else begin
                if ($urandom_range(0, 199) == 0)
                    threshold = ($urandom_range(0, 7) == 0) ? '0 : SAMPLE_W'($urandom_range(1, 4000));
                step(0, $urandom_range(0, 99) < 70, SAMPLE_W'($urandom_range(0, 6000)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
